// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and helpers for the reg_file write-back path.
//                Defines the buffered write request and a one-hot decode
//                used to build the pending-destination mask.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One buffered register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Decode a register index to a 32-bit one-hot mask.
  function automatic logic [31:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
    logic [31:0] m;
    m     = 32'd0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_if
//  Description : Bundle of the write-back front end's result inputs, the
//                reg_file write port and the hazard-tracking outputs.
//  Ports       : master - result producers / consumers (issue side, bench)
//                slave  - rf_writeback
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_writeback_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ALU result source (valid/ready)
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  // Load return source (no backpressure)
  logic              ld_valid;
  logic [4:0]        ld_rd;
  logic [XLEN-1:0]   ld_data;
  // reg_file write port
  logic              reg_we;
  logic [4:0]        rd;
  logic [XLEN-1:0]   data_in;
  // Hazard tracking
  logic [31:0]       pend_mask;
  logic [CNT_W-1:0]  buf_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, reg_we, rd, data_in, pend_mask, buf_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, reg_we, rd, data_in, pend_mask, buf_count
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : In-order buffer of wb_req_t entries for ALU results that
//                lost write-port arbitration. Exposes per-entry valid and rd
//                so the parent can build the pending-destination mask.
//  Ports       : clk, rst (sync, active-low)
//                push_i/data_i  - enqueue at tail (ignored when full)
//                pop_i/head_o   - dequeue head (ignored when empty)
//                full_o, empty_o, count_o - occupancy
//                valid_o, rd_o  - per-slot valid bit and destination
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic                                push_i,
  input  wire wb_req_t                             data_i,
  input  wire logic                                pop_i,
  output wb_req_t                                  head_o,
  output logic                                     full_o,
  output logic                                     empty_o,
  output logic [$clog2(DEPTH):0]                   count_o,
  output logic [DEPTH-1:0]                         valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]         rd_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  logic w_do_push;
  logic w_do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap
  // naturally. count can only move within [0, DEPTH] because of the guards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (w_do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Payload storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[tail_q] <= data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_o[i] = mem_q[i].rd;
    end
  end

  assign head_o  = mem_q[head_q];
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback
//  Description : Write-side front end for reg_file. Arbitrates loads (always
//                win) against buffered and fresh ALU results, and registers
//                the winner onto the reg_file write port (latency 1).
//  Ports       : clk  - clock
//                rst  - synchronous active-low reset
//                bus  - rf_writeback_if.slave (ALU/load inputs, write port,
//                       pend_mask, buf_count)
//  Revision    : 1.0  initial release
// ============================================================================
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rf_writeback_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t                          w_head;
  wb_req_t                          w_alu_req;
  logic                             w_full;
  logic                             w_empty;
  logic [CNT_W-1:0]                 w_count;
  logic [DEPTH-1:0]                 w_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_rds;
  logic                             w_alu_acc;
  logic                             w_push;
  logic                             w_pop;
  logic [31:0]                      w_pend;

  logic                  reg_we_q, reg_we_d;
  logic [REG_ADDR_W-1:0] rd_q,     rd_d;
  logic [XLEN-1:0]       data_q,   data_d;

  // Readiness comes from occupancy alone, so a full buffer refuses even in
  // a cycle where it is also popping.
  assign w_alu_acc = bus.alu_valid & ~w_full;
  assign w_alu_req = '{rd: bus.alu_rd, data: bus.alu_data};

  always_comb begin
    reg_we_d = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (bus.ld_valid) begin
      // Load cannot stall; a load to x0 still occupies the slot.
      reg_we_d = |bus.ld_rd;
      rd_d     = bus.ld_rd;
      data_d   = bus.ld_data;
      w_push   = w_alu_acc & (|bus.alu_rd);
    end else if (!w_empty) begin
      // x0 writes are never buffered, so the head is always a real write.
      w_pop    = 1'b1;
      reg_we_d = 1'b1;
      rd_d     = w_head.rd;
      data_d   = w_head.data;
      w_push   = w_alu_acc & (|bus.alu_rd);
    end else if (w_alu_acc) begin
      reg_we_d = |bus.alu_rd;
      rd_d     = bus.alu_rd;
      data_d   = bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      reg_we_q <= reg_we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_alu_req),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .valid_o (w_valid),
    .rd_o    (w_rds)
  );

  always_comb begin
    w_pend = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        w_pend = w_pend | onehot_rd(w_rds[i]);
      end
    end
  end

  assign bus.alu_ready = ~w_full;
  assign bus.reg_we    = reg_we_q;
  assign bus.rd        = rd_q;
  assign bus.data_in   = data_q;
  assign bus.pend_mask = w_pend;
  assign bus.buf_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback
//  Description : Self-checking bench for rf_writeback. Directed scenarios
//                plus randomized traffic compared against a queue-based
//                reference model of the write-back rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk;
  logic rst;

  rf_writeback_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  rf_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_chk;   // rd/data are defined for this cycle
  logic        last_acc;  // ALU offer accepted on the last edge

  int n_tests;
  int n_fail;

  function automatic logic [31:0] model_pend();
    logic [31:0] m;
    m = 32'd0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] dat(input logic [4:0] r);
    return 32'hD000_0000 | {27'd0, r};
  endfunction

  // Apply the write-back rules to the current inputs, then advance one edge.
  task automatic tick();
    ent_t e;
    logic acc;
    if (!rst) begin
      mq.delete();
      exp_we   = 1'b0;
      exp_rd   = 5'd0;
      exp_data = 32'd0;
      exp_chk  = 1'b1;
      last_acc = 1'b0;
    end else begin
      acc      = bus.alu_valid && (mq.size() < DEPTH);
      last_acc = acc;
      if (bus.ld_valid) begin
        exp_we   = (bus.ld_rd != 5'd0);
        exp_rd   = bus.ld_rd;
        exp_data = bus.ld_data;
        exp_chk  = exp_we;
        if (acc && bus.alu_rd != 5'd0) mq.push_back('{bus.alu_rd, bus.alu_data});
      end else if (mq.size() > 0) begin
        e        = mq.pop_front();
        exp_we   = 1'b1;
        exp_rd   = e.rd;
        exp_data = e.data;
        exp_chk  = 1'b1;
        if (acc && bus.alu_rd != 5'd0) mq.push_back('{bus.alu_rd, bus.alu_data});
      end else if (acc) begin
        exp_we   = (bus.alu_rd != 5'd0);
        exp_rd   = bus.alu_rd;
        exp_data = bus.alu_data;
        exp_chk  = exp_we;
      end else begin
        exp_we  = 1'b0;
        exp_chk = 1'b1;  // idle: rd/data hold
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", bus.reg_we); end
    n_tests++; if (bus.rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
    n_tests++; if (bus.data_in !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_in); end
    n_tests++; if (bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", bus.pend_mask); end
    n_tests++; if (bus.buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.buf_count); end
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", bus.alu_ready); end
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    idle_inputs();
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    tick();
    idle_inputs();
    n_tests++; if (bus.reg_we !== 1'b1) begin n_fail++; $display("FAIL bypass_we: got %0b want 1", bus.reg_we); end
    n_tests++; if (bus.rd !== 5'd5) begin n_fail++; $display("FAIL bypass_rd: got %0d want 5", bus.rd); end
    n_tests++; if (bus.data_in !== 32'h1234) begin n_fail++; $display("FAIL bypass_data: got %h want 1234", bus.data_in); end
    n_tests++; if (bus.buf_count !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", bus.buf_count); end
    n_tests++; if (bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL bypass_pend: got %h want 0", bus.pend_mask); end
    tick();
    // Idle cycle: write enable drops, address/data hold.
    n_tests++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %0b want 0", bus.reg_we); end
    n_tests++; if (bus.rd !== 5'd5 || bus.data_in !== 32'h1234) begin n_fail++; $display("FAIL idle_hold: got rd=%0d data=%h want rd=5 data=1234", bus.rd, bus.data_in); end
  endtask

  task automatic test_ld_priority();
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd3; bus.ld_data  = 32'hAAAA;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hBBBB;
    tick();
    idle_inputs();
    n_tests++; if (bus.reg_we !== 1'b1 || bus.rd !== 5'd3 || bus.data_in !== 32'hAAAA) begin n_fail++; $display("FAIL ldprio_commit: got we=%0b rd=%0d data=%h want we=1 rd=3 data=aaaa", bus.reg_we, bus.rd, bus.data_in); end
    n_tests++; if (bus.buf_count !== 3'd1) begin n_fail++; $display("FAIL ldprio_count: got %0d want 1", bus.buf_count); end
    n_tests++; if (bus.pend_mask !== 32'h80) begin n_fail++; $display("FAIL ldprio_pend: got %h want 80", bus.pend_mask); end
    tick();
    n_tests++; if (bus.reg_we !== 1'b1 || bus.rd !== 5'd7 || bus.data_in !== 32'hBBBB) begin n_fail++; $display("FAIL ldprio_drain: got we=%0b rd=%0d data=%h want we=1 rd=7 data=bbbb", bus.reg_we, bus.rd, bus.data_in); end
    n_tests++; if (bus.pend_mask !== 32'd0 || bus.buf_count !== 3'd0) begin n_fail++; $display("FAIL ldprio_empty: got pend=%h count=%0d want 0/0", bus.pend_mask, bus.buf_count); end
  endtask

  // Loads held for `hold` cycles while ALU results first..first+5 are
  // offered; then drain and require all six to commit in order.
  task automatic fill_and_drain(input string tag, input logic [4:0] first,
                                input logic [4:0] ld_dst, input int hold);
    logic [4:0] nxt;
    logic [4:0] want;
    int         ncommit;
    nxt = first;
    for (int c = 0; c < hold; c++) begin
      bus.ld_valid  = 1'b1; bus.ld_rd = ld_dst; bus.ld_data = 32'h5000 + c;
      bus.alu_valid = 1'b1; bus.alu_rd = nxt; bus.alu_data = dat(nxt);
      tick();
      if (last_acc) nxt = nxt + 5'd1;
      if (c == 3) begin
        n_tests++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL %s_full_ready: got %0b want 0", tag, bus.alu_ready); end
        n_tests++; if (bus.buf_count !== 3'd4) begin n_fail++; $display("FAIL %s_full_count: got %0d want 4", tag, bus.buf_count); end
        n_tests++; if (bus.pend_mask !== (32'hF << first)) begin n_fail++; $display("FAIL %s_full_pend: got %h want %h", tag, bus.pend_mask, 32'hF << first); end
      end
    end
    bus.ld_valid = 1'b0;
    want    = first;
    ncommit = 0;
    for (int i = 0; i < 12; i++) begin
      bus.alu_valid = (nxt < first + 5'd6);
      bus.alu_rd    = nxt;
      bus.alu_data  = dat(nxt);
      if (i == 0) begin
        n_tests++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL %s_refuse_full: got %0b want 0", tag, bus.alu_ready); end
      end
      if (i == 1) begin
        n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_again: got %0b want 1", tag, bus.alu_ready); end
      end
      tick();
      if (last_acc) nxt = nxt + 5'd1;
      if (i < 6) begin
        n_tests++; if (bus.reg_we !== 1'b1) begin n_fail++; $display("FAIL %s_consec_we[%0d]: got %0b want 1", tag, i, bus.reg_we); end
      end
      if (bus.reg_we === 1'b1) begin
        n_tests++; if (bus.rd !== want || bus.data_in !== dat(want)) begin n_fail++; $display("FAIL %s_order: got rd=%0d data=%h want rd=%0d data=%h", tag, bus.rd, bus.data_in, want, dat(want)); end
        want = want + 5'd1;
        ncommit++;
      end
    end
    idle_inputs();
    n_tests++; if (ncommit != 6) begin n_fail++; $display("FAIL %s_commit_count: got %0d want 6", tag, ncommit); end
  endtask

  task automatic test_fill_hold();
    fill_and_drain("hold", 5'd1, 5'd20, 6);
  endtask

  task automatic test_full_drain();
    // Loads to x0 still block the pop, so the buffer fills behind them.
    fill_and_drain("drain", 5'd8, 5'd0, 4);
  endtask

  task automatic test_x0();
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    tick();
    idle_inputs();
    n_tests++; if (bus.reg_we !== 1'b0 || bus.buf_count !== 3'd0 || bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL x0_alu: got we=%0b count=%0d pend=%h want 0/0/0", bus.reg_we, bus.buf_count, bus.pend_mask); end
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd2; bus.ld_data  = 32'h22;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hDEAD;
    tick();
    idle_inputs();
    n_tests++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL x0_ld_we: got %0b want 0", bus.reg_we); end
    n_tests++; if (bus.buf_count !== 3'd1 || bus.pend_mask !== 32'h200) begin n_fail++; $display("FAIL x0_ld_delay: got count=%0d pend=%h want 1/200", bus.buf_count, bus.pend_mask); end
    tick();
    n_tests++; if (bus.reg_we !== 1'b1 || bus.rd !== 5'd9 || bus.data_in !== 32'h99) begin n_fail++; $display("FAIL x0_delayed_pop: got we=%0b rd=%0d data=%h want 1/9/99", bus.reg_we, bus.rd, bus.data_in); end
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd0; bus.ld_data  = 32'h1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h2;
    tick();
    idle_inputs();
    n_tests++; if (bus.reg_we !== 1'b0 || bus.buf_count !== 3'd0) begin n_fail++; $display("FAIL x0_both: got we=%0b count=%0d want 0/0", bus.reg_we, bus.buf_count); end
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c < 3; c++) begin
      bus.ld_valid  = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h44;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(11 + c); bus.alu_data = dat(5'(11 + c));
      tick();
    end
    idle_inputs();
    n_tests++; if (bus.buf_count !== 3'd3) begin n_fail++; $display("FAIL midrst_fill: got %0d want 3", bus.buf_count); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_tests++; if (bus.reg_we !== 1'b0 || bus.buf_count !== 3'd0 || bus.pend_mask !== 32'd0 || bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got we=%0b count=%0d pend=%h ready=%0b want 0/0/0/1", bus.reg_we, bus.buf_count, bus.pend_mask, bus.alu_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost[%0d]: got we=1 rd=%0d want no commit", i, bus.rd); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 79) != 0);
      bus.ld_valid  = ($urandom_range(0, 9) < 4);
      bus.ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.ld_data   = $urandom;
      bus.alu_valid = ($urandom_range(0, 9) < 7);
      bus.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.alu_data  = $urandom;
      tick();
      n_tests++; if (bus.reg_we !== exp_we) begin n_fail++; $display("FAIL rand_we[%0d]: got %0b want %0b", i, bus.reg_we, exp_we); end
      if (exp_chk) begin
        n_tests++; if (bus.rd !== exp_rd || bus.data_in !== exp_data) begin n_fail++; $display("FAIL rand_wr[%0d]: got rd=%0d data=%h want rd=%0d data=%h", i, bus.rd, bus.data_in, exp_rd, exp_data); end
      end
      n_tests++; if (bus.buf_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.buf_count, mq.size()); end
      n_tests++; if (bus.alu_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0b want %0b", i, bus.alu_ready, mq.size() < DEPTH); end
      n_tests++; if (bus.pend_mask !== model_pend()) begin n_fail++; $display("FAIL rand_pend[%0d]: got %h want %h", i, bus.pend_mask, model_pend()); end
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    exp_we   = 1'b0;
    exp_rd   = 5'd0;
    exp_data = 32'd0;
    exp_chk  = 1'b1;
    last_acc = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_ld_priority();
    test_fill_hold();
    test_full_drain();
    test_x0();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side front end for reg_file. It arbitrates between two result sources and drives reg_file's write port: single-cycle ALU results, and load data returning from data memory.
- Load returns cannot stall, so they always win. ALU results that lose arbitration wait in a small in-order buffer.
- Exports a pending-destination mask so the issue/hazard logic can stall on RAW/WAW against buffered writes.

Parameters:
- DEPTH, 4, ALU buffer entries; power of two, >= 2.
- XLEN, 32, data width; must match reg_file.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_ready  out  1  buffer can accept an ALU result; asserted iff count < DEPTH.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load data returns this cycle; no backpressure.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load data.
- reg_we  out  1  write enable to reg_file (registered).
- rd  out  5  write address to reg_file (registered).
- data_in  out  XLEN  write data to reg_file (registered).
- pend_mask  out  32  bit r = 1 iff a buffered entry targets register r.
- buf_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0 at an edge):
  - count, head and tail pointers are 0; reg_we=0, rd=0, data_in=0.
  - pend_mask and buf_count read 0, and alu_ready reads 1 after that edge.
  - Reset mid-operation discards all buffered writes; nothing is committed on the reset edge.
- ALU acceptance: an ALU result is accepted when alu_valid && alu_ready. alu_ready depends only on count, never on the same-cycle pop, so a full buffer refuses even while draining.
- Commit priority, evaluated each cycle; the winner appears on reg_we/rd/data_in after the next edge (latency 1):
  1. ld_valid: commit the load.
  2. Otherwise, buffer non-empty: pop the head and commit it.
  3. Otherwise, an accepted ALU result bypasses the buffer and commits directly.
  4. Otherwise reg_we=0. rd and data_in hold their last values.
- Buffering of an accepted ALU result that does not commit this cycle (cases 1 and 2):
  - It is pushed at the tail.
  - With a simultaneous push and pop, count is unchanged.
  - Buffered entries always commit in acceptance order.
- rd==0 writes from either source:
  - They are accepted or consumed normally, but produce reg_we=0 and are never buffered.
  - They still win their priority slot, so a load to x0 blocks the buffer pop for that cycle.
- Ordering against loads: a load may commit before an older buffered ALU write to the same rd. Preventing this WAW is the issue logic's job via pend_mask. rf_writeback does not reorder or merge.
- pend_mask: combinational OR of decoded rd over valid entries. It includes an entry being pushed only from the next cycle, and excludes a popped entry from the next cycle.
- Pointers wrap modulo DEPTH. count saturates by construction: no push when full, no pop when empty.
- Reg_file write/read timing: a committed write is visible on reg_file reads two edges after the source presented it.

Decomposition:
- Package rf_pkg:
  - REG_ADDR_W=5 and XLEN=32.
  - Typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
  - Function onehot_rd(rd) returning 32 bits.
- Sub-module wb_fifo (DEPTH x wb_req_t, synchronous active-low reset, push/pop/full/empty/count, per-entry valid + rd exported for pend_mask).
- rf_writeback contains only the arbiter and the output register.

Test Plan:
- Reset, then alu_valid with rd=5, data=0x1234 for one cycle, ld_valid=0 -> next cycle reg_we=1, rd=5, data_in=0x1234; buf_count=0; pend_mask=0.
- Same cycle: ld_valid rd=3 data=0xAAAA and alu_valid rd=7 data=0xBBBB -> cycle+1 commits x3=0xAAAA; buf_count=1; pend_mask=0x80; cycle+2 commits x7=0xBBBB; pend_mask=0.
- Hold ld_valid for 6 cycles while offering ALU results rd=1..6 -> after 4 accepts alu_ready=0, buf_count=4, pend_mask=0x1E. After ld_valid drops, x1..x4 commit in order on consecutive cycles. x5 and x6 are accepted only once alu_ready returns.
- Full buffer, ld_valid low, alu_valid high -> one pop per cycle. The ALU result is refused in the full cycle and accepted the next cycle. Order is preserved.
- alu_valid rd=0 data=0xFFFF; also ld_valid rd=0 -> reg_we stays 0, nothing buffered; a queued entry is delayed one cycle by the load-to-x0.
- Fill 3 entries, assert rst=0 for one edge -> reg_we=0, buf_count=0, pend_mask=0, alu_ready=1; no buffered write ever commits.
